mmio_responder: RTL and testbench
=================================

# mmio_responder

Memory-mapped I/O responder on the CPU data-memory port, beside scdatamem. It answers the single-cycle CPU's loads and stores in a small register window: a free-running cycle counter, a byte-stream output FIFO drained by an external reader over a valid/ready handshake, and a halt/exit-code register. It lets the bench end a run and collect program output without peeking at memory.

## Interface
Parameters:
- BASE, 32'h0000_1000: word-aligned base address of the 32-byte window.
- DEPTH, 8: output FIFO depth. Power of two, at least 2.

Ports:
- clock, in, 1: single clock shared with the CPU.
- reset, in, 1: asynchronous, active-high.
- we, in, 1: CPU store strobe (same signal that drives scdatamem).
- addr, in, 32: CPU data address (aluout).
- datain, in, 32: CPU store data.
- sel, out, 1: combinational. High when addr[31:5] == BASE[31:5]. The top uses it to mux dataout over memout and to gate the scdatamem write.
- dataout, out, 32: combinational read data for addr.
- out_valid, out, 1: FIFO non-empty.
- out_data, out, 8: FIFO head byte.
- out_ready, in, 1: reader accepts the head byte.
- halt, out, 1: program has halted.
- exit_code, out, 32: value written to HALT.

## Operation
Register map (offset = addr[4:2]; addr[1:0] ignored; unmapped offsets read 0 and ignore writes):
- 0x00 CYCLE (RO): 32-bit counter.
- 0x04 CTRL (RW): bit0 EN (reset 1). bit1 CLR reads 0; writing 1 zeroes the counter.
- 0x08 TXDATA (WO, reads 0): write pushes datain[7:0].
- 0x0C STATUS (RO; W1C on bit2): bit0 empty, bit1 full, bit2 OVF sticky, bits[7:4] count (saturates at 15), other bits 0.
- 0x10 HALT (WO, reads exit_code): write sets halt and latches datain into exit_code.

Rules:
- A write is effective only when we && sel at a rising clock edge.
- Counter: increments by 1 per clock while EN && !halt. Wraps 32'hFFFF_FFFF → 0. A CLR write loads 0 at that edge, with no increment that cycle. It counts from the next edge if EN.
- FIFO push:
  - Push happens on a TXDATA write while !halt.
  - If the FIFO is full at that edge, the byte is dropped and OVF is set. This holds even if a pop occurs the same edge.
- FIFO pop: on out_valid && out_ready.
- Simultaneous push and pop on a non-full, non-empty FIFO: count unchanged, data order preserved.
- Pointers wrap modulo DEPTH. Count is held in a log2(DEPTH)+1 bit register.
- OVF: set by a dropped push; cleared by writing STATUS with bit2=1. If both happen at the same edge, set wins.
- Halt:
  - halt is sticky until reset.
  - Once halt is high, all CPU writes are ignored, including a second HALT write. The counter freezes.
  - The FIFO still drains.

## Timing
- All reads are combinational, same cycle as addr, as scdatamem behaves for loads.
- A store is visible to a load in the following cycle. Example: STATUS reads count+1 one cycle after a TXDATA write.
- out_valid and out_data are registered outputs. The first byte is presented the cycle after the push that made the FIFO non-empty.
- Reset values (asynchronous): counter 0, EN 1, FIFO empty (out_valid 0, out_data 0), OVF 0, halt 0, exit_code 0.
- Reset asserted mid-operation discards FIFO contents immediately. No handshake completes while reset is high.

## Structure
- Package mmio_pkg holds:
  - the offset constants OFF_CYCLE, OFF_CTRL, OFF_TXDATA, OFF_STATUS, OFF_HALT;
  - the STATUS bit positions;
  - the CTRL bit positions.
- One sub-module, mmio_fifo: synchronous FIFO, 8-bit wide, DEPTH deep. Ports: push, pop, din, dout, full, empty, count. Async active-high reset.
- mmio_responder contains only decode, the counter, OVF, halt and the read mux.

## Test plan
- Reset release, no stores: CYCLE reads 10 after 10 edges. out_valid=0, halt=0, STATUS=32'h1.
- Store 0x48, then 0x69 to TXDATA, with out_ready=0: STATUS=32'h20. Raise out_ready: out_data=0x48, then 0x69, then out_valid=0.
- Nine TXDATA stores with DEPTH=8, no drain: count 8, full=1, OVF=1. Drained bytes are the first eight in order. Writing STATUS=0x4 clears OVF.
- Full FIFO, out_ready=1 and a TXDATA write at the same edge: write dropped, OVF=1, count 7.
- CTRL=0x0: counter holds. Then CTRL=0x3: counter 0 at that edge, 1 at the next edge. Separately, preload counter 32'hFFFF_FFFF: it wraps to 0.
- HALT write 0x2A: halt=1 and exit_code=0x2A next cycle, CYCLE frozen. Later TXDATA and HALT writes are ignored. Pending FIFO bytes still drain. Asserting reset clears everything asynchronously.

Source files
------------

// File: rtl/mmio_pkg.sv
// Shared definitions for the MMIO responder register window.
// Latency: n/a (constants, types and a helper only).
// Backpressure: n/a.
package mmio_pkg;

    // Word offsets within the 32-byte window (addr[4:2]).
    localparam logic [2:0] OFF_CYCLE  = 3'd0;
    localparam logic [2:0] OFF_CTRL   = 3'd1;
    localparam logic [2:0] OFF_TXDATA = 3'd2;
    localparam logic [2:0] OFF_STATUS = 3'd3;
    localparam logic [2:0] OFF_HALT   = 3'd4;

    // CTRL bit positions.
    localparam int CTRL_EN_BIT  = 0;
    localparam int CTRL_CLR_BIT = 1;

    // STATUS bit positions.
    localparam int ST_EMPTY_BIT = 0;
    localparam int ST_FULL_BIT  = 1;
    localparam int ST_OVF_BIT   = 2;
    localparam int ST_CNT_LSB   = 4;
    localparam int ST_CNT_W     = 4;

    typedef struct packed {
        logic [23:0] rsvd_hi;
        logic [3:0]  count;
        logic        rsvd_lo;
        logic        ovf;
        logic        full;
        logic        empty;
    } status_t;

    // FIFO occupancy as reported in STATUS: clamps at 15 for deep FIFOs.
    function automatic logic [ST_CNT_W-1:0] sat_count(input logic [31:0] c);
        return (c > 32'd15) ? 4'hF : c[ST_CNT_W-1:0];
    endfunction

endpackage

// File: rtl/mmio_fifo.sv
// Byte FIFO, DEPTH entries, with registered head byte and registered non-empty flag.
// Latency: a push into an empty FIFO is visible on dout/!empty the next cycle.
// Backpressure: push while full is dropped; pop while empty is ignored.
// Ports: clock/reset (async active-high), push/din, pop, dout (head byte),
//        full, empty, count (log2(DEPTH)+1 bits).
module mmio_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [7:0]               din,
    output logic [7:0]               dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [7:0]    head_q, head_d;
    logic          vld_q, vld_d;
    logic [7:0]    mem_q [DEPTH];
    logic          push_ok, pop_ok;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = !vld_q;
    assign count   = count_q;
    assign dout    = head_q;
    assign push_ok = push && !full;
    assign pop_ok  = pop && vld_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
        if (push_ok && !pop_ok)      count_d = count_q + CW'(1);
        else if (!push_ok && pop_ok) count_d = count_q - CW'(1);
        vld_d = (count_d != '0);
        // The new head is the incoming byte only when the FIFO holds nothing
        // else after this edge's pop; that is exactly when the read pointer
        // lands on the slot being written.
        if (!vld_d)
            head_d = 8'h00;
        else if (push_ok && (wr_ptr_q == rd_ptr_d))
            head_d = din;
        else
            head_d = mem_q[rd_ptr_d];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= 8'h00;
            vld_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
            vld_q    <= vld_d;
        end
    end

    // Storage needs no reset: entries are only read once written.
    always_ff @(posedge clock) begin
        if (push_ok) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/mmio_responder.sv
// MMIO window on the CPU data port: cycle counter, CTRL, TX byte FIFO, STATUS, HALT.
// Latency: reads combinational; stores take effect at the clock edge; TX byte out one cycle after push.
// Backpressure: TX pushes into a full FIFO are dropped and flag OVF; reader drains via out_valid/out_ready.
// Ports: clock, reset (async active-high); we/addr/datain from CPU; sel/dataout to CPU mux;
//        out_valid/out_data/out_ready byte stream; halt/exit_code run status.
module mmio_responder
    import mmio_pkg::*;
#(
    parameter logic [31:0] BASE  = 32'h0000_1000,
    parameter int          DEPTH = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] datain,
    output logic        sel,
    output logic [31:0] dataout,
    output logic        out_valid,
    output logic [7:0]  out_data,
    input  logic        out_ready,
    output logic        halt,
    output logic [31:0] exit_code
);

    logic [31:0] cycle_q, cycle_d;
    logic        en_q, en_d;
    logic        ovf_q, ovf_d;
    logic        halt_q, halt_d;
    logic [31:0] exit_q, exit_d;

    logic [2:0]  off;
    logic        wr_en;
    logic        ctrl_wr, tx_push, status_wr, halt_wr;
    logic        fifo_full, fifo_empty;
    logic [7:0]  fifo_dout;
    logic [$clog2(DEPTH):0] fifo_count;
    logic        addr_unused;
    status_t     status;

    assign sel         = (addr[31:5] == BASE[31:5]);
    assign off         = addr[4:2];
    assign addr_unused = ^addr[1:0];

    // Everything the CPU can write is frozen once halted.
    assign wr_en     = we && sel && !halt_q;
    assign ctrl_wr   = wr_en && (off == OFF_CTRL);
    assign tx_push   = wr_en && (off == OFF_TXDATA);
    assign status_wr = wr_en && (off == OFF_STATUS);
    assign halt_wr   = wr_en && (off == OFF_HALT);

    mmio_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (tx_push),
        .pop   (out_ready),
        .din   (datain[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign out_valid = !fifo_empty;
    assign out_data  = fifo_dout;
    assign halt      = halt_q;
    assign exit_code = exit_q;

    always_comb begin
        cycle_d = cycle_q;
        en_d    = en_q;
        ovf_d   = ovf_q;
        halt_d  = halt_q;
        exit_d  = exit_q;

        // CLR takes priority over the increment for that one edge.
        if (ctrl_wr && datain[CTRL_CLR_BIT])
            cycle_d = 32'd0;
        else if (en_q && !halt_q)
            cycle_d = cycle_q + 32'd1;
        if (ctrl_wr)
            en_d = datain[CTRL_EN_BIT];

        // A drop on the same edge as a W1C leaves OVF set.
        if (status_wr && datain[ST_OVF_BIT])
            ovf_d = 1'b0;
        if (tx_push && fifo_full)
            ovf_d = 1'b1;

        if (halt_wr) begin
            halt_d = 1'b1;
            exit_d = datain;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cycle_q <= 32'd0;
            en_q    <= 1'b1;
            ovf_q   <= 1'b0;
            halt_q  <= 1'b0;
            exit_q  <= 32'd0;
        end else begin
            cycle_q <= cycle_d;
            en_q    <= en_d;
            ovf_q   <= ovf_d;
            halt_q  <= halt_d;
            exit_q  <= exit_d;
        end
    end

    always_comb begin
        status         = '0;
        status.empty   = fifo_empty;
        status.full    = fifo_full;
        status.ovf     = ovf_q;
        status.count   = sat_count(32'(fifo_count));

        dataout = 32'd0;
        if (sel) begin
            case (off)
                OFF_CYCLE:  dataout = cycle_q;
                OFF_CTRL:   dataout = {31'd0, en_q};
                OFF_STATUS: dataout = status;
                OFF_HALT:   dataout = exit_q;
                default:    dataout = 32'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_responder.sv
module tb_mmio_responder;

    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam int          DEPTH = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        we = 1'b0;
    logic [31:0] addr = 32'd0;
    logic [31:0] datain = 32'd0;
    logic        sel;
    logic [31:0] dataout;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_ready = 1'b0;
    logic        halt;
    logic [31:0] exit_code;

    int          n_cmp = 0;
    int          n_bad = 0;
    int unsigned edges = 0;
    logic [7:0]  exp_q[$];
    bit          halt_m = 1'b0;

    mmio_responder #(.BASE(BASE), .DEPTH(DEPTH)) dut (
        .clock     (clock),
        .reset     (reset),
        .we        (we),
        .addr      (addr),
        .datain    (datain),
        .sel       (sel),
        .dataout   (dataout),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .halt      (halt),
        .exit_code (exit_code)
    );

    always #5 clock = ~clock;
    always @(posedge clock) edges++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] a_of(input logic [2:0] off);
        return BASE + {27'd0, off, 2'b00};
    endfunction

    // Store: drive now, effective at the next rising edge; returns at edge+1.
    task automatic cpu_wr(input logic [31:0] a, input logic [31:0] d);
        we = 1'b1; addr = a; datain = d;
        if (a[31:5] == BASE[31:5] && !halt_m) begin
            if (a[4:2] == 3'd2 && exp_q.size() < DEPTH) exp_q.push_back(d[7:0]);
            if (a[4:2] == 3'd4) halt_m = 1'b1;
        end
        @(posedge clock); #1;
        we = 1'b0;
    endtask

    task automatic chk_rd(input string tag, input logic [2:0] off, input logic [31:0] exp);
        addr = a_of(off);
        #1;
        check(tag, dataout, exp);
    endtask

    // Scoreboard consumer: a byte leaves on the next edge whenever valid&&ready now.
    always @(negedge clock) begin
        if (!reset && out_valid && out_ready) begin
            check("drain_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) check("drain_byte", 32'(out_data), 32'(exp_q.pop_front()));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned e0;
        logic [31:0] frozen;

        // Reset state.
        repeat (2) @(posedge clock);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_halt", 32'(halt), 32'd0);
        check("rst_exit", exit_code, 32'd0);
        reset = 1'b0;
        repeat (10) @(posedge clock);
        #1;
        chk_rd("cycle_10", 3'd0, 32'd10);
        check("sel_in", 32'(sel), 32'd1);
        chk_rd("status_idle", 3'd3, 32'h1);
        chk_rd("ctrl_reset", 3'd1, 32'h1);

        // Counter enable and clear.
        cpu_wr(a_of(3'd1), 32'h0);
        chk_rd("cycle_dis", 3'd0, 32'd11);
        repeat (3) @(posedge clock);
        #1;
        chk_rd("cycle_hold", 3'd0, 32'd11);
        cpu_wr(a_of(3'd1), 32'h3);
        chk_rd("cycle_clr", 3'd0, 32'd0);
        @(posedge clock); #1;
        chk_rd("cycle_after_clr", 3'd0, 32'd1);

        // Wrap from all-ones.
        force dut.cycle_q = 32'hFFFF_FFFF;
        release dut.cycle_q;
        @(posedge clock); #1;
        chk_rd("cycle_wrap", 3'd0, 32'd0);
        e0 = edges;

        // Two bytes, then drain.
        cpu_wr(a_of(3'd2), 32'h48);
        chk_rd("status_one", 3'd3, 32'h10);
        cpu_wr(a_of(3'd2), 32'h69);
        chk_rd("status_two", 3'd3, 32'h20);
        check("head_48", 32'(out_data), 32'h48);
        out_ready = 1'b1;
        repeat (4) @(posedge clock);
        #1;
        out_ready = 1'b0;
        check("valid_after_drain", 32'(out_valid), 32'd0);
        check("left_after_two", 32'(exp_q.size()), 32'd0);

        // Overflow with nine stores.
        for (int i = 0; i < 9; i++) cpu_wr(a_of(3'd2), 32'h10 + 32'(i));
        chk_rd("status_ovf", 3'd3, 32'h86);
        check("head_first", 32'(out_data), 32'h10);
        out_ready = 1'b1;
        repeat (10) @(posedge clock);
        #1;
        out_ready = 1'b0;
        check("left_after_nine", 32'(exp_q.size()), 32'd0);
        chk_rd("status_drained_ovf", 3'd3, 32'h5);
        cpu_wr(a_of(3'd3), 32'h4);
        chk_rd("status_w1c", 3'd3, 32'h1);

        // Full FIFO: pop and dropped push on the same edge.
        for (int i = 0; i < 8; i++) cpu_wr(a_of(3'd2), 32'h30 + 32'(i));
        chk_rd("status_full", 3'd3, 32'h82);
        out_ready = 1'b1;
        cpu_wr(a_of(3'd2), 32'hEE);
        out_ready = 1'b0;
        chk_rd("status_pop_drop", 3'd3, 32'h74);
        cpu_wr(a_of(3'd3), 32'h4);
        chk_rd("status_w1c_7", 3'd3, 32'h70);

        // Store outside the window is not ours.
        addr = BASE + 32'h28;
        #1;
        check("sel_out", 32'(sel), 32'd0);
        cpu_wr(BASE + 32'h28, 32'h77);
        chk_rd("status_outside", 3'd3, 32'h70);

        // Halt.
        cpu_wr(a_of(3'd4), 32'h2A);
        frozen = edges - e0;
        check("halt_set", 32'(halt), 32'd1);
        check("exit_code", exit_code, 32'h2A);
        chk_rd("halt_read", 3'd4, 32'h2A);
        chk_rd("cycle_at_halt", 3'd0, frozen);
        cpu_wr(a_of(3'd2), 32'h99);
        cpu_wr(a_of(3'd4), 32'h55);
        cpu_wr(a_of(3'd1), 32'h2);
        check("exit_kept", exit_code, 32'h2A);
        chk_rd("status_halted", 3'd3, 32'h70);
        chk_rd("cycle_frozen", 3'd0, frozen);
        out_ready = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        out_ready = 1'b0;
        chk_rd("status_part_drain", 3'd3, 32'h40);

        // Asynchronous reset mid-cycle.
        #2;
        reset = 1'b1;
        #1;
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_data", 32'(out_data), 32'd0);
        check("arst_halt", 32'(halt), 32'd0);
        check("arst_exit", exit_code, 32'd0);
        chk_rd("arst_status", 3'd3, 32'h1);
        chk_rd("arst_cycle", 3'd0, 32'd0);
        exp_q.delete();
        halt_m = 1'b0;
        @(posedge clock); #1;
        reset = 1'b0;
        chk_rd("ctrl_after_arst", 3'd1, 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
